// File: rtl/mem_stress_pkg.sv
// Shared definitions for the memory stress driver.
//
// Contents:
//   state_t / ST_*       FSM state encoding (IDLE, REQ, RSP, DONE)
//   XS_SHIFT_A/B/C       xorshift32 shift amounts (13, 17, 5)
//   WRITE_BIT, ADDR_LSB,
//   WDATA_MSB            positions of the request fields in a PRNG word
//   xorshift32_next()    one xorshift32 step
package mem_stress_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RSP  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int unsigned XS_SHIFT_A = 13;
  localparam int unsigned XS_SHIFT_B = 17;
  localparam int unsigned XS_SHIFT_C = 5;

  // A PRNG word r maps to a request as:
  //   write = r[31], addr = r[16 +: ADDR_BITS], wdata = r[15:0]
  localparam int unsigned WRITE_BIT  = 31;
  localparam int unsigned ADDR_LSB   = 16;
  localparam int unsigned WDATA_MSB  = 15;
  localparam int unsigned WDATA_BITS = WDATA_MSB + 1;

  function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << XS_SHIFT_A);
    y = y ^ (y >> XS_SHIFT_B);
    y = y ^ (y << XS_SHIFT_C);
    return y;
  endfunction

endpackage

// File: rtl/mem_stress_driver_prng.sv
// stress_prng: 32-bit xorshift32 generator.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset; loads SEED (0 becomes 1)
//   advance  in   step the generator once this cycle
//   state    out  current 32-bit PRNG value
module stress_prng
  import mem_stress_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        advance,
  output logic [31:0] state
);

  // An all-zero xorshift state never leaves zero, so a zero seed is replaced.
  localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED_INIT;
    end else if (advance) begin
      state <= xorshift32_next(state);
    end
  end

endmodule

// File: rtl/mem_stress_driver.sv
// mem_stress_driver: issues pseudo-random reads/writes to a memory under
// test, keeps a shadow copy of every written word and checks read data
// against it.
//
// Parameters: ADDR_BITS, NUM_OPS, SEED, TIMEOUT_CYCLES
// Optional response watchdog: define MEM_STRESS_TIMEOUT_EN.
//
// Ports:
//   clock, reset_n            clock / async active-low reset
//   start                     level; launches a run from IDLE
//   req_valid, req_ready      request handshake
//   req_write, req_addr,
//   req_wdata                 request payload (held while stalled)
//   rsp_valid, rsp_rdata      read response, one per accepted read
//   done, error, err_count,
//   op_count, first_err_addr,
//   timeout                   run status
module mem_stress_driver
  import mem_stress_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 5,
  parameter int unsigned NUM_OPS        = 32'd16777216,
  parameter logic [31:0] SEED           = 32'd1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_BITS-1:0]  req_addr,
  output logic [WDATA_BITS-1:0] req_wdata,
  input  logic                  rsp_valid,
  input  logic [WDATA_BITS-1:0] rsp_rdata,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           err_count,
  output logic [31:0]           op_count,
  output logic [ADDR_BITS-1:0]  first_err_addr,
  output logic                  timeout
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  state_t                  state;
  logic [31:0]             prng_state;
  logic                    prng_advance;
  logic                    prng_unused;

  logic [WDATA_BITS-1:0]   shadow [DEPTH];
  logic [DEPTH-1:0]        written;

  logic                    wr_done;
  logic                    rd_handshake;
  logic                    rd_done;
  logic                    op_done;
  logic                    last_op;
  logic                    mismatch;
  logic                    tmo_hit;

  // The PRNG only steps when an op completes, so the payload is naturally
  // stable across stalls and still names the read address while in RSP.
  assign req_write = prng_state[WRITE_BIT];
  assign req_addr  = prng_state[ADDR_LSB +: ADDR_BITS];
  assign req_wdata = prng_state[WDATA_MSB:0];
  assign prng_unused = ^prng_state;

  assign req_valid = (state == ST_REQ);
  assign done      = (state == ST_DONE);

  assign wr_done      = req_valid && req_ready && req_write;
  assign rd_handshake = req_valid && req_ready && !req_write;
  assign rd_done      = (state == ST_RSP) && rsp_valid;
  assign op_done      = wr_done || rd_done;
  assign last_op      = op_done && (op_count == NUM_OPS - 1);
  assign mismatch     = rd_done && written[req_addr] && (rsp_rdata != shadow[req_addr]);

  assign prng_advance = ((state == ST_IDLE) && start) || op_done;

  stress_prng #(.SEED(SEED)) u_prng (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (prng_advance),
    .state   (prng_state)
  );

  // NOTE: the shadow array has no reset; validity is tracked by the
  // resettable written[] bits, so the data can map onto plain RAM.
  always_ff @(posedge clock) begin
    if (wr_done) begin
      shadow[req_addr] <= req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      written        <= '0;
      op_count       <= '0;
      err_count      <= '0;
      error          <= 1'b0;
      first_err_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_REQ;
        ST_REQ: begin
          if (rd_handshake)  state <= ST_RSP;
          else if (last_op)  state <= ST_DONE;
        end
        ST_RSP: begin
          if (rsp_valid)     state <= last_op ? ST_DONE : ST_REQ;
          else if (tmo_hit)  state <= ST_DONE;
        end
        default: state <= ST_DONE;
      endcase

      if (wr_done) written[req_addr] <= 1'b1;
      if (op_done) op_count <= op_count + 32'd1;

      if (mismatch) begin
        // err_count never returns to zero, so zero means "no mismatch yet".
        if (err_count == 16'd0)     first_err_addr <= req_addr;
        if (err_count != 16'hFFFF)  err_count      <= err_count + 16'd1;
      end
      if (mismatch || tmo_hit) error <= 1'b1;
    end
  end

`ifdef MEM_STRESS_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Fires in the TIMEOUT_CYCLES-th consecutive RSP cycle without a response.
  assign tmo_hit = (state == ST_RSP) && !rsp_valid && (tmo_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (rd_handshake)          tmo_cnt <= '0;
      else if (state == ST_RSP)  tmo_cnt <= tmo_cnt + 32'd1;
      if (tmo_hit)               timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stress_driver.sv
// Self-checking bench for mem_stress_driver (ADDR_BITS=5, NUM_OPS=1000,
// SEED=1, TIMEOUT_CYCLES=8). Works with and without MEM_STRESS_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_mem_stress_driver;

  localparam int AB = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          req_ready = 1'b0;
  logic          rsp_valid = 1'b0;
  logic [15:0]   rsp_rdata = 16'h0;
  logic          req_valid, req_write, done, error, timeout;
  logic [AB-1:0] req_addr, first_err_addr;
  logic [15:0]   req_wdata, err_count;
  logic [31:0]   op_count;

  always #5 clock = ~clock;

  mem_stress_driver #(
    .ADDR_BITS(AB), .NUM_OPS(1000), .SEED(32'd1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .done(done), .error(error), .err_count(err_count), .op_count(op_count),
    .first_err_addr(first_err_addr), .timeout(timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Hand-computed first three requests after SEED=1 (xorshift32: 0x00042021,
  // 0x04080601, 0x9DCCA8C5) with a stall count applied before accepting each.
  typedef struct {
    int          stall;
    logic        exp_write;
    logic [4:0]  exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;
  vec_t vecs[3];

  // Ideal memory model and request-sequence model.
  logic [15:0] mem [32];
  bit          mem_wr [32];
  logic [31:0] model_r;
  int          model_miss = 0;
  int          n_ops = 0;
  logic [21:0] rec[$];
  logic        last_w;
  logic [4:0]  last_a;
  logic [15:0] last_d;
  bit          last_chk;

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem_wr[i] = 1'b0;
    model_r = 32'd1;
    n_ops = 0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) check("req_valid_wait", {31'd0, req_valid}, 32'd1);
  endtask

  // One complete op against the ideal memory; when corrupt is set and the
  // op is a read of a previously written address, the returned data is
  // inverted.
  task automatic do_op(input bit corrupt);
    bit ok;
    wait_req(ok);
    last_w = req_write;
    last_a = req_addr;
    last_d = req_wdata;
    if ({last_w, last_a, last_d} !== {model_r[31], model_r[20:16], model_r[15:0]})
      model_miss++;
    model_r  = xs(model_r);
    n_ops++;
    last_chk = 1'b0;
    if (!ok) return;
    req_ready = 1'b1;
    @(negedge clock);
    req_ready = 1'b0;
    if (last_w) begin
      mem[last_a]    = last_d;
      mem_wr[last_a] = 1'b1;
    end else begin
      last_chk  = mem_wr[last_a];
      rsp_valid = 1'b1;
      rsp_rdata = last_chk ? (corrupt ? ~mem[last_a] : mem[last_a]) : 16'hDEAD;
      @(negedge clock);
      rsp_valid = 1'b0;
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    model_r = xs(32'd1);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_status_zero(input string tag);
    check({tag, "_req_valid"},  {31'd0, req_valid}, 32'd0);
    check({tag, "_done"},       {31'd0, done}, 32'd0);
    check({tag, "_error"},      {31'd0, error}, 32'd0);
    check({tag, "_timeout"},    {31'd0, timeout}, 32'd0);
    check({tag, "_err_count"},  {16'd0, err_count}, 32'd0);
    check({tag, "_op_count"},   op_count, 32'd0);
    check({tag, "_first_addr"}, {27'd0, first_err_addr}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not end in time");
    $fatal(1, "time limit");
  end

  initial begin
    int   rerun_miss;
    int   n_run1;
    bit   found;
    logic [4:0] bad_a;

    vecs[0] = '{stall: 0, exp_write: 1'b0, exp_addr: 5'h04, exp_wdata: 16'h2021};
    vecs[1] = '{stall: 2, exp_write: 1'b0, exp_addr: 5'h08, exp_wdata: 16'h0601};
    vecs[2] = '{stall: 1, exp_write: 1'b1, exp_addr: 5'h0C, exp_wdata: 16'hA8C5};

    // ---- reset state ----
    clear_model();
    repeat (3) @(negedge clock);
    check_status_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_no_start_valid", {31'd0, req_valid}, 32'd0);

    // ---- run 1: table of first requests ----
    start_run();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < vecs[i].stall; k++) @(negedge clock);
      check($sformatf("vec%0d_valid", i), {31'd0, req_valid}, 32'd1);
      check($sformatf("vec%0d_write", i), {31'd0, req_write}, {31'd0, vecs[i].exp_write});
      check($sformatf("vec%0d_addr", i),  {27'd0, req_addr},  {27'd0, vecs[i].exp_addr});
      check($sformatf("vec%0d_wdata", i), {16'd0, req_wdata}, {16'd0, vecs[i].exp_wdata});
      do_op(1'b0);
      rec.push_back({last_w, last_a, last_d});
    end
    check("run1_op_count_3", op_count, 32'd3);
    check("unwritten_read_no_error", {31'd0, error}, 32'd0);

    // ---- stall 5 cycles with stray rsp_valid in REQ ----
    rsp_valid = 1'b1;
    rsp_rdata = 16'hBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("stall%0d_payload", k), {10'd0, req_valid, req_write, req_addr, req_wdata},
            {10'd0, 1'b1, model_r[31], model_r[20:16], model_r[15:0]});
      check($sformatf("stall%0d_op_count", k), op_count, 32'd3);
    end
    rsp_valid = 1'b0;
    check("stray_rsp_no_error", {31'd0, error}, 32'd0);
    do_op(1'b0);
    rec.push_back({last_w, last_a, last_d});

    // ---- advance to a read and stall in RSP, then reset ----
    for (int i = 0; i < 50 && model_r[31] == 1'b1; i++) begin
      do_op(1'b0);
      rec.push_back({last_w, last_a, last_d});
    end
    n_run1 = n_ops;
    req_ready = 1'b1;
    @(negedge clock);
    req_ready = 1'b0;
    repeat (4) @(negedge clock);
    check("rsp_wait_no_valid", {31'd0, req_valid}, 32'd0);
    check("rsp_wait_no_done", {31'd0, done}, 32'd0);
    check("rsp_wait_op_count", op_count, n_run1);
    #2 reset_n = 1'b0;
    #1 check_status_zero("mid_rsp_reset");
    @(negedge clock);
    reset_n = 1'b1;
    clear_model();

    // ---- run 2: full ideal run, replays run 1 ----
    rerun_miss = 0;
    model_miss = 0;
    start_run();
    for (int i = 0; i < 1000; i++) begin
      do_op(1'b0);
      if (i < rec.size() && {last_w, last_a, last_d} !== rec[i]) rerun_miss++;
    end
    @(negedge clock);
    check("rerun_sequence", rerun_miss, 0);
    check("run2_model_seq", model_miss, 0);
    check("run2_done", {31'd0, done}, 32'd1);
    check("run2_op_count", op_count, 32'd1000);
    check("run2_err_count", {16'd0, err_count}, 32'd0);
    check("run2_error", {31'd0, error}, 32'd0);
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    check("done_terminal", {30'd0, done, req_valid}, 32'd2);
    check("done_op_count_hold", op_count, 32'd1000);

    // ---- run 3: corrupted reads ----
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    clear_model();
    model_miss = 0;
    start_run();
    found = 1'b0;
    bad_a = '0;
    for (int i = 0; i < 400 && !found; i++) begin
      do_op(1'b1);
      if (last_chk) begin
        found = 1'b1;
        bad_a = last_a;
      end
    end
    check("corrupt1_found", {31'd0, found}, 32'd1);
    check("corrupt1_err_count", {16'd0, err_count}, 32'd1);
    check("corrupt1_error", {31'd0, error}, 32'd1);
    check("corrupt1_first_addr", {27'd0, first_err_addr}, {27'd0, bad_a});
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      do_op(model_r[20:16] != bad_a);
      if (last_chk && last_a != bad_a) found = 1'b1;
    end
    check("corrupt2_found", {31'd0, found}, 32'd1);
    check("corrupt2_err_count", {16'd0, err_count}, 32'd2);
    check("corrupt2_first_addr_kept", {27'd0, first_err_addr}, {27'd0, bad_a});
    check("run3_op_count", op_count, n_ops);
    check("run3_model_seq", model_miss, 0);

    // ---- response watchdog ----
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    clear_model();
    start_run();
    check("wd_first_is_read", {31'd0, req_write}, 32'd0);
    req_ready = 1'b1;
    @(negedge clock);
    req_ready = 1'b0;
`ifdef MEM_STRESS_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      @(negedge clock);
      check($sformatf("wd_rsp_cycle%0d_not_done", k), {30'd0, done, timeout}, 32'd0);
    end
    @(negedge clock);
    check("wd_timeout", {31'd0, timeout}, 32'd1);
    check("wd_error", {31'd0, error}, 32'd1);
    check("wd_done", {31'd0, done}, 32'd1);
    check("wd_op_count", op_count, 32'd0);
`else
    repeat (20) @(negedge clock);
    check("no_wd_timeout", {31'd0, timeout}, 32'd0);
    check("no_wd_still_waiting", {30'd0, done, req_valid}, 32'd0);
    check("no_wd_error", {31'd0, error}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stress_driver.md
MEM_STRESS_DRIVER -- requirements
Module: mem_stress_driver

Interface
REQ-001 Parameter ADDR_BITS, default 5: request address width; the shadow table has 2^ADDR_BITS entries.
REQ-002 Parameter NUM_OPS, default 2^24: completed operations per test run.
REQ-003 Parameter SEED, default 32'd1: PRNG reset state; value 0 SHALL be replaced by 1.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: response watchdog limit.
REQ-005 Port clock, input, 1: sole clock, rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port start, input, 1: level; begins a run from IDLE.
REQ-008 Ports req_valid (output, 1), req_ready (input, 1): request handshake.
REQ-009 Ports req_write (output, 1), req_addr (output, ADDR_BITS), req_wdata (output, 16): request payload.
REQ-010 Ports rsp_valid (input, 1), rsp_rdata (input, 16): read response, one per accepted read.
REQ-011 Ports done (output, 1), error (output, 1), err_count (output, 16), op_count (output, 32), first_err_addr (output, ADDR_BITS), timeout (output, 1): status.

Function
REQ-012 FSM states IDLE, REQ, RSP, DONE; IDLE->REQ when start=1; REQ->RSP on read handshake; REQ->REQ on write handshake; RSP->REQ on rsp_valid; ->DONE when op_count reaches NUM_OPS.
REQ-013 PRNG: xorshift32 (x^=x<<13; x^=x>>17; x^=x<<5), advanced once on IDLE->REQ and once per completed op.
REQ-014 Payload from current PRNG value r: req_write=r[31], req_addr=r[16+ADDR_BITS-1:16], req_wdata=r[15:0]; stable while req_valid=1 and req_ready=0.
REQ-015 req_valid SHALL be 1 exactly in REQ; at most one read outstanding; no request issued in RSP.
REQ-016 Write completes on handshake cycle: shadow[addr]<=wdata, written[addr]<=1, op_count+1.
REQ-017 Read completes on rsp_valid in RSP: if written[addr] and rsp_rdata!=shadow[addr], err_count+1 (saturating at 16'hFFFF), error<=1 (sticky), first_err_addr captured on first mismatch only; op_count+1 regardless.
REQ-018 Reads of never-written addresses SHALL NOT be checked.
REQ-019 rsp_valid outside RSP SHALL be ignored.
REQ-020 done=1 in DONE only; DONE is terminal until reset; start ignored outside IDLE.

Reset
REQ-021 reset_n=0 SHALL immediately force IDLE, req_valid=0, done=0, error=0, timeout=0, err_count=0, op_count=0, first_err_addr=0, PRNG=SEED, all written bits 0; shadow data not reset.
REQ-022 Reset mid-REQ or mid-RSP SHALL abandon the outstanding op without counting it.

Configuration
REQ-023 Macro MEM_STRESS_TIMEOUT_EN defined: a counter cleared on entry to RSP, incremented each RSP cycle; on reaching TIMEOUT_CYCLES, timeout<=1 (sticky), error<=1, FSM->DONE.
REQ-024 Macro undefined: no watchdog logic; timeout tied to 0; RSP waits indefinitely.

Structure
REQ-025 Shared package mem_stress_pkg SHALL hold the state enum, the xorshift shift constants (13,17,5) and the payload field positions.
REQ-026 Sub-module stress_prng (inputs clock, reset_n, advance; output 32-bit state) SHALL implement REQ-013.

Verification
REQ-027 SEED=1, start pulse -> first request r=32'h00042021: req_write=0, req_addr=5'h04, req_wdata=16'h2021; read of unwritten address, no error.
REQ-028 Ideal memory model (1-cycle rsp), NUM_OPS=1000 -> done=1, op_count=1000, err_count=0, error=0.
REQ-029 Model corrupting one read of a written address -> err_count=1, error=1, first_err_addr equals that address.
REQ-030 req_ready held 0 for 5 cycles -> req_valid and payload constant throughout; op_count unchanged.
REQ-031 MEM_STRESS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no rsp_valid -> timeout=1, error=1, done=1 after 8 RSP cycles.
REQ-032 reset_n pulsed low while in RSP -> all status zero next cycle, PRNG back to SEED, rerun reproduces identical request sequence.
